// File: rtl/ttt_turn_controller_pkg.sv
// rtl/ttt_turn_controller_pkg.sv - shared cell encoding, FSM states and win-line table
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b10;
  localparam logic [1:0] CELL_P1    = 2'b11;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ttt_state_e;

  // Rows, columns, then the two diagonals; row-major cell numbering.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_mark(input logic p);
    return p ? CELL_P1 : CELL_P0;
  endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// rtl/ttt_turn_controller_if.sv - move request / cell drive / game status bundle
interface ttt_turn_controller_if;

  logic        start;
  logic        move_valid;
  logic [3:0]  move_idx;
  logic        move_ready;
  logic        move_err;
  logic [8:0]  cell_we;
  logic        player;
  logic [17:0] board;
  logic [1:0]  state;
  logic        winner_vld;
  logic        winner;
  logic [3:0]  move_count;
  logic        timeout;

  modport master (
    output start, move_valid, move_idx,
    input  move_ready, move_err, cell_we, player, board, state,
           winner_vld, winner, move_count, timeout
  );

  modport slave (
    input  start, move_valid, move_idx,
    output move_ready, move_err, cell_we, player, board, state,
           winner_vld, winner, move_count, timeout
  );

endinterface

// File: rtl/ttt_line_checker.sv
// rtl/ttt_line_checker.sv - combinational three-in-a-row detector for one player
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic        player_i,
  output logic        win_o
);

  logic [1:0] mark;

  assign mark = cell_mark(player_i);

  always_comb begin
    win_o = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (board_i[2*WIN_LINES[l][0] +: 2] == mark &&
          board_i[2*WIN_LINES[l][1] +: 2] == mark &&
          board_i[2*WIN_LINES[l][2] +: 2] == mark) begin
        win_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_turn_controller.sv
// rtl/ttt_turn_controller.sv - tic-tac-toe move validation, turn sequencing, win/draw detection
// Optional per-turn timer enabled by defining TTT_MOVE_TIMEOUT_EN.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ttt_turn_controller_if.slave   ctrl_if
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ttt_state_e  state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        player_q, player_d;
  logic [3:0]  count_q, count_d;
  logic [8:0]  cell_we_q, cell_we_d;
  logic        move_err_q, move_err_d;
  logic        winner_vld_q, winner_vld_d;
  logic        winner_q, winner_d;
  logic        timeout_q, timeout_d;

  logic        win;
  logic        handshake;
  logic        legal;
  logic        expired;
  logic [8:0]  idx_onehot;
  logic [17:0] board_shifted;

  assign handshake     = ctrl_if.move_valid && (state_q == ST_PLAY);
  assign idx_onehot    = 9'd1 << ctrl_if.move_idx;
  assign board_shifted = board_q >> {ctrl_if.move_idx, 1'b0};
  assign legal         = (ctrl_if.move_idx <= 4'd8) && (board_shifted[1:0] == CELL_EMPTY);

  ttt_line_checker u_line_checker (
    .board_i  (board_q),
    .player_i (player_q),
    .win_o    (win)
  );

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  assign expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Any entry into PLAY (start or return from CHECK) restarts the count.
  always_comb begin
    timer_d = '0;
    if (!ctrl_if.start && state_q == ST_PLAY && state_d == ST_PLAY) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    player_d     = player_q;
    count_d      = count_q;
    cell_we_d    = '0;
    move_err_d   = 1'b0;
    winner_vld_d = winner_vld_q;
    winner_d     = winner_q;
    timeout_d    = timeout_q;

    // start outranks any move presented in the same cycle.
    if (ctrl_if.start) begin
      state_d      = ST_PLAY;
      board_d      = '0;
      player_d     = FIRST_PLAYER;
      count_d      = '0;
      winner_vld_d = 1'b0;
      winner_d     = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_PLAY: begin
          if (handshake && legal) begin
            cell_we_d = idx_onehot;
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (idx_onehot[i]) board_d[2*i +: 2] = cell_mark(player_q);
            end
            if (count_q != 4'd9) count_d = count_q + 4'd1;
            state_d = ST_CHECK;
          end else begin
            move_err_d = handshake;
            if (expired) begin
              state_d      = ST_DONE;
              winner_vld_d = 1'b1;
              winner_d     = ~player_q;
              timeout_d    = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (win) begin
            state_d      = ST_DONE;
            winner_vld_d = 1'b1;
            winner_d     = player_q;
          end else if (count_q == 4'd9) begin
            state_d      = ST_DONE;
            winner_vld_d = 1'b0;
          end else begin
            state_d  = ST_PLAY;
            player_d = ~player_q;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      board_q      <= '0;
      player_q     <= FIRST_PLAYER;
      count_q      <= '0;
      cell_we_q    <= '0;
      move_err_q   <= 1'b0;
      winner_vld_q <= 1'b0;
      winner_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      player_q     <= player_d;
      count_q      <= count_d;
      cell_we_q    <= cell_we_d;
      move_err_q   <= move_err_d;
      winner_vld_q <= winner_vld_d;
      winner_q     <= winner_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ctrl_if.move_ready = (state_q == ST_PLAY);
  assign ctrl_if.move_err   = move_err_q;
  assign ctrl_if.cell_we    = cell_we_q;
  assign ctrl_if.player     = player_q;
  assign ctrl_if.board      = board_q;
  assign ctrl_if.state      = state_q;
  assign ctrl_if.winner_vld = winner_vld_q;
  assign ctrl_if.winner     = winner_q;
  assign ctrl_if.move_count = count_q;
  assign ctrl_if.timeout    = timeout_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// tb/tb_ttt_turn_controller.sv - directed and randomized games against a board-array reference model
module tb_ttt_turn_controller;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ttt_turn_controller_if dut_if ();

  ttt_turn_controller #(
    .FIRST_PLAYER   (1'b0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (dut_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference game: -1 empty, otherwise the owning player.
  int mdl_cell [9];
  int mdl_player;
  int mdl_count;
  bit mdl_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mdl_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      if (mdl_cell[i] >= 0) b = b | (18'(2 + mdl_cell[i]) << (2 * i));
    end
    return b;
  endfunction

  function automatic bit mdl_wins(input int p);
    for (int r = 0; r < 3; r++) begin
      if (mdl_cell[3*r] == p && mdl_cell[3*r+1] == p && mdl_cell[3*r+2] == p) return 1'b1;
      if (mdl_cell[r] == p && mdl_cell[r+3] == p && mdl_cell[r+6] == p) return 1'b1;
    end
    if (mdl_cell[0] == p && mdl_cell[4] == p && mdl_cell[8] == p) return 1'b1;
    if (mdl_cell[2] == p && mdl_cell[4] == p && mdl_cell[6] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 9; i++) mdl_cell[i] = -1;
    mdl_player = 0;
    mdl_count  = 0;
    mdl_done   = 1'b0;
  endtask

  task automatic new_game();
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    mdl_clear();
    chk("start_state", dut_if.state, 1);
    chk("start_board", dut_if.board, 0);
    chk("start_player", dut_if.player, 0);
    chk("start_count", dut_if.move_count, 0);
    chk("start_ready", dut_if.move_ready, 1);
    chk("start_winvld", dut_if.winner_vld, 0);
    chk("start_timeout", dut_if.timeout, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_we", dut_if.cell_we, 0);
      chk("idle_state", dut_if.state, mdl_done ? 3 : 1);
    end
  endtask

  task automatic play_move(input int idx);
    bit legal;
    legal = 1'b0;
    if (idx <= 8) legal = (mdl_cell[idx] < 0);
    dut_if.move_valid = 1'b1;
    dut_if.move_idx   = 4'(idx);
    step();
    dut_if.move_valid = 1'b0;
    if (!legal) begin
      chk("err_pulse", dut_if.move_err, 1);
      chk("err_no_we", dut_if.cell_we, 0);
      chk("err_state", dut_if.state, 1);
      chk("err_board", dut_if.board, mdl_board());
      chk("err_player", dut_if.player, mdl_player);
      chk("err_count", dut_if.move_count, mdl_count);
      step();
      chk("err_one_cycle", dut_if.move_err, 0);
    end else begin
      mdl_cell[idx] = mdl_player;
      mdl_count++;
      chk("mv_we", dut_if.cell_we, 32'(1) << idx);
      chk("mv_player", dut_if.player, mdl_player);
      chk("mv_board", dut_if.board, mdl_board());
      chk("mv_count", dut_if.move_count, mdl_count);
      chk("mv_check_state", dut_if.state, 2);
      chk("mv_check_ready", dut_if.move_ready, 0);
      chk("mv_no_err", dut_if.move_err, 0);
      step();
      chk("mv_we_one_cycle", dut_if.cell_we, 0);
      if (mdl_wins(mdl_player)) begin
        mdl_done = 1'b1;
        chk("win_state", dut_if.state, 3);
        chk("win_vld", dut_if.winner_vld, 1);
        chk("win_player", dut_if.winner, mdl_player);
      end else if (mdl_count == 9) begin
        mdl_done = 1'b1;
        chk("draw_state", dut_if.state, 3);
        chk("draw_vld", dut_if.winner_vld, 0);
      end else begin
        mdl_player ^= 1;
        chk("next_state", dut_if.state, 1);
        chk("next_player", dut_if.player, mdl_player);
        chk("next_ready", dut_if.move_ready, 1);
      end
      chk("mv_timeout", dut_if.timeout, 0);
    end
  endtask

  task automatic poke_done();
    dut_if.move_valid = 1'b1;
    dut_if.move_idx   = 4'($urandom_range(0, 15));
    step();
    dut_if.move_valid = 1'b0;
    chk("done_we", dut_if.cell_we, 0);
    chk("done_err", dut_if.move_err, 0);
    chk("done_state", dut_if.state, 3);
    chk("done_ready", dut_if.move_ready, 0);
    chk("done_count", dut_if.move_count, mdl_count);
    chk("done_board", dut_if.board, mdl_board());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seq1 [5];
    int seq2 [9];
    int last_cyc;
    int cyc;
    bit found;
    int q [$];
    int pick;
    int guard;

    seq1 = '{0, 3, 1, 4, 2};
    seq2 = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    dut_if.start      = 1'b0;
    dut_if.move_valid = 1'b0;
    dut_if.move_idx   = 4'd0;
    mdl_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dut_if.state, 0);
    chk("rst_board", dut_if.board, 0);
    chk("rst_player", dut_if.player, 0);
    chk("rst_count", dut_if.move_count, 0);
    chk("rst_we", dut_if.cell_we, 0);
    chk("rst_err", dut_if.move_err, 0);
    chk("rst_winvld", dut_if.winner_vld, 0);
    chk("rst_winner", dut_if.winner, 0);
    chk("rst_timeout", dut_if.timeout, 0);
    chk("rst_ready", dut_if.move_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("idle_ready", dut_if.move_ready, 0);

    // Row 0 win for player 0.
    new_game();
    foreach (seq1[i]) play_move(seq1[i]);
    chk("t1_winvld", dut_if.winner_vld, 1);
    chk("t1_winner", dut_if.winner, 0);
    chk("t1_count", dut_if.move_count, 5);
    poke_done();

    // Full-board draw, then count must stay at 9.
    new_game();
    foreach (seq2[i]) play_move(seq2[i]);
    chk("t2_winvld", dut_if.winner_vld, 0);
    chk("t2_count", dut_if.move_count, 9);
    chk("t2_full", dut_if.board & 18'h2AAAA, 18'h2AAAA);
    poke_done();
    chk("t2_count_sat", dut_if.move_count, 9);

    new_game();
    play_move(4);
    play_move(4);
    chk("t3_player", dut_if.player, 1);
    play_move(12);
    play_move(15);
    play_move(9);

    // Asynchronous reset between edges.
    new_game();
    play_move(0);
    play_move(1);
    play_move(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", dut_if.state, 0);
    chk("arst_board", dut_if.board, 0);
    chk("arst_ready", dut_if.move_ready, 0);
    chk("arst_count", dut_if.move_count, 0);
    @(negedge clk) rst_n = 1'b1;
    mdl_clear();
    dut_if.move_valid = 1'b1;
    dut_if.move_idx   = 4'd0;
    step();
    chk("idle_move_we", dut_if.cell_we, 0);
    chk("idle_move_err", dut_if.move_err, 0);
    chk("idle_move_state", dut_if.state, 0);
    dut_if.start    = 1'b1;
    dut_if.move_idx = 4'd4;
    step();
    dut_if.start      = 1'b0;
    dut_if.move_valid = 1'b0;
    chk("startmv_we", dut_if.cell_we, 0);
    chk("startmv_err", dut_if.move_err, 0);
    chk("startmv_state", dut_if.state, 1);
    chk("startmv_count", dut_if.move_count, 0);
    chk("startmv_board", dut_if.board, 0);

    // Back-to-back requests with move_valid held high.
    new_game();
    cyc = 0;
    last_cyc = 0;
    dut_if.move_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dut_if.move_idx = 4'(k);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        step();
        cyc++;
        if (dut_if.cell_we != 0) begin
          found = 1'b1;
          if (k == 2) dut_if.move_valid = 1'b0;
          chk("b2b_we", dut_if.cell_we, 32'(1) << k);
          chk("b2b_player", dut_if.player, k % 2);
          if (k > 0) chk("b2b_gap", cyc - last_cyc, 2);
          last_cyc = cyc;
        end
      end
      if (!found) chk("b2b_accept_bound", 0, 1);
      mdl_cell[k] = k % 2;
    end
    dut_if.move_valid = 1'b0;
    mdl_count  = 3;
    mdl_player = 1;
    step();
    chk("b2b_state", dut_if.state, 1);
    chk("b2b_board", dut_if.board, mdl_board());
    chk("b2b_next_player", dut_if.player, 1);

    // Random games: idles, occasional illegal moves, occasional restart.
    for (int g = 0; g < 12; g++) begin
      new_game();
      guard = 0;
      while (!mdl_done && guard < 30) begin
        guard++;
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin
          q.delete();
          for (int i = 0; i < 9; i++) if (mdl_cell[i] >= 0) q.push_back(i);
          if (q.size() > 0 && $urandom_range(0, 1) == 1) pick = q[$urandom_range(0, q.size() - 1)];
          else pick = $urandom_range(9, 15);
          play_move(pick);
          idle($urandom_range(0, 2));
        end
        q.delete();
        for (int i = 0; i < 9; i++) if (mdl_cell[i] < 0) q.push_back(i);
        play_move(q[$urandom_range(0, q.size() - 1)]);
        if (!mdl_done && $urandom_range(0, 19) == 0) new_game();
      end
      if (mdl_done) poke_done();
      else chk("rand_game_bound", 0, 1);
    end

`ifdef TTT_MOVE_TIMEOUT_EN
    new_game();
    idle(TMO - 1);
    step();
    chk("tmo_state", dut_if.state, 3);
    chk("tmo_flag", dut_if.timeout, 1);
    chk("tmo_winvld", dut_if.winner_vld, 1);
    chk("tmo_winner", dut_if.winner, 1);
    chk("tmo_ready", dut_if.move_ready, 0);

    new_game();
    idle(TMO - 1);
    play_move(4);
    chk("tmo_last_cycle_state", dut_if.state, 1);
    idle(TMO - 1);
    step();
    chk("tmo_p1_state", dut_if.state, 3);
    chk("tmo_p1_flag", dut_if.timeout, 1);
    chk("tmo_p1_winner", dut_if.winner, 0);

    // Illegal attempts keep the timer running.
    new_game();
    idle(3);
    play_move(12);
    idle(2);
    step();
    chk("tmo_err_state", dut_if.state, 3);
    chk("tmo_err_flag", dut_if.timeout, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
